// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS fetch stage and its pipeline registers.
//   RESET_PC_DEF  : default PC loaded on reset
//   NOP_INSTR_DEF : default bubble instruction word
//   fetch_state_e : fetch state machine encoding
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HELD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: PC, instruction word and valid bit.
// Ports:
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_load             : capture {i_pc, i_instr} as a valid instruction
//   i_bubble, i_flush  : replace the instruction with NOP, clear valid, keep PC
//   i_pc, i_instr      : incoming PC and instruction word
//   o_pc, o_instr      : registered PC and instruction
//   o_valid            : register holds a real instruction
// Priority: flush/bubble over load over hold.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic        i_flush,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_valid
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc    <= 32'h0000_0000;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_flush || i_bubble) begin
      // PC is deliberately left alone so decode still sees the last real PC
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline.
// Holds the fetch PC, runs a req/ack handshake with variable-latency
// instruction memory and fills the IF/ID register.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   NPc                 : next PC from next-PC mux (used only on accept)
//   Stall, Flush        : hazard-unit controls
//   Imem_req/addr       : fetch request and address (address == Pc)
//   Imem_ack/rdata      : memory response
//   Pc                  : current fetch PC
//   Pc_D, InstrD, Valid_D : IF/ID contents
//   Fetch_busy          : request outstanding without ack this cycle
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPc,
  input  logic        Stall,
  input  logic        Flush,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] Pc,
  output logic [31:0] Pc_D,
  output logic [31:0] InstrD,
  output logic        Valid_D,
  output logic        Fetch_busy
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_buf;

  logic         w_accept;
  logic         w_bubble;
  logic         w_buf_load;
  logic         w_req;
  logic         w_busy;
  logic [31:0]  w_ifid_instr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH:   if (Imem_ack && Stall) w_state_nxt = HELD;
      HELD:    if (!Stall)            w_state_nxt = FETCH;
      default: w_state_nxt = FETCH;
    endcase
  end

  always_comb begin
    w_req      = 1'b0;
    w_busy     = 1'b0;
    w_accept   = 1'b0;
    w_bubble   = 1'b0;
    w_buf_load = 1'b0;
    case (r_state)
      FETCH: begin
        w_req      = 1'b1;
        w_busy     = !Imem_ack;
        w_accept   = Imem_ack && !Stall;
        w_bubble   = !Imem_ack && !Stall;
        // ack arrived while decode is stalled: park the word until release
        w_buf_load = Imem_ack && Stall;
      end
      HELD: begin
        w_accept = !Stall;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc  <= RESET_PC;
      r_buf <= 32'h0000_0000;
    end else begin
      if (w_accept)   r_pc  <= NPc;
      if (w_buf_load) r_buf <= Imem_rdata;
    end
  end

  assign w_ifid_instr = (r_state == HELD) ? r_buf : Imem_rdata;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_load   (w_accept),
    .i_bubble (w_bubble),
    .i_flush  (Flush),
    .i_pc     (r_pc),
    .i_instr  (w_ifid_instr),
    .o_pc     (Pc_D),
    .o_instr  (InstrD),
    .o_valid  (Valid_D)
  );

  assign Pc         = r_pc;
  assign Imem_addr  = r_pc;
  assign Imem_req   = w_req;
  assign Fetch_busy = w_busy;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] NPc;
  logic        Stall;
  logic        Flush;
  logic        Imem_req;
  logic [31:0] Imem_addr;
  logic        Imem_ack;
  logic [31:0] Imem_rdata;
  logic [31:0] Pc;
  logic [31:0] Pc_D;
  logic [31:0] InstrD;
  logic        Valid_D;
  logic        Fetch_busy;

  logic        npc_auto;
  logic [31:0] npc_val;
  logic        rd_force;
  logic [31:0] rd_val;

  int compared;
  int mismatched;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .NPc        (NPc),
    .Stall      (Stall),
    .Flush      (Flush),
    .Imem_req   (Imem_req),
    .Imem_addr  (Imem_addr),
    .Imem_ack   (Imem_ack),
    .Imem_rdata (Imem_rdata),
    .Pc         (Pc),
    .Pc_D       (Pc_D),
    .InstrD     (InstrD),
    .Valid_D    (Valid_D),
    .Fetch_busy (Fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: each word is a fixed function of its address
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  always_comb begin
    NPc        = npc_auto ? (Pc + 32'd4) : npc_val;
    Imem_rdata = rd_force ? rd_val : mem(Imem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; Imem_ack = 1'b1; Stall = 1'b0; Flush = 1'b0;
    npc_auto = 1'b1; rd_force = 1'b0;
    repeat (3) tick();
    compared++; if (Pc !== 32'h0000_3000) begin mismatched++; $display("FAIL reset_pc got %h exp %h", Pc, 32'h0000_3000); end
    compared++; if (Valid_D !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b exp 0", Valid_D); end
    compared++; if (InstrD !== 32'h0) begin mismatched++; $display("FAIL reset_instr got %h exp 0", InstrD); end
    compared++; if (Pc_D !== 32'h0) begin mismatched++; $display("FAIL reset_pcd got %h exp 0", Pc_D); end
    compared++; if (Imem_addr !== 32'h0000_3000) begin mismatched++; $display("FAIL reset_addr got %h exp 3000", Imem_addr); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] ep;
      ep = 32'h0000_3000 + 32'(4 * i);
      tick();
      compared++; if (Pc_D !== ep) begin mismatched++; $display("FAIL b2b_pcd[%0d] got %h exp %h", i, Pc_D, ep); end
      compared++; if (InstrD !== mem(ep)) begin mismatched++; $display("FAIL b2b_instr[%0d] got %h exp %h", i, InstrD, mem(ep)); end
      compared++; if (Valid_D !== 1'b1) begin mismatched++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, Valid_D); end
      compared++; if (Pc !== ep + 32'd4) begin mismatched++; $display("FAIL b2b_pc[%0d] got %h exp %h", i, Pc, ep + 32'd4); end
    end
  endtask

  // Pc starts at 300C, IF/ID holds the instruction from 3008
  task automatic test_slow_mem();
    logic [31:0] last_pcd;
    last_pcd = 32'h0000_3008;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] ep;
      ep = 32'h0000_300C + 32'(4 * k);
      for (int w = 0; w < 2; w++) begin
        Imem_ack = 1'b0;
        #1;
        compared++; if (Fetch_busy !== 1'b1) begin mismatched++; $display("FAIL slow_busy[%0d.%0d] got %b exp 1", k, w, Fetch_busy); end
        compared++; if (Imem_req !== 1'b1) begin mismatched++; $display("FAIL slow_req[%0d.%0d] got %b exp 1", k, w, Imem_req); end
        tick();
        compared++; if (Valid_D !== 1'b0) begin mismatched++; $display("FAIL slow_bubble_valid[%0d.%0d] got %b exp 0", k, w, Valid_D); end
        compared++; if (InstrD !== 32'h0) begin mismatched++; $display("FAIL slow_bubble_instr[%0d.%0d] got %h exp 0", k, w, InstrD); end
        compared++; if (Pc !== ep) begin mismatched++; $display("FAIL slow_pc_hold[%0d.%0d] got %h exp %h", k, w, Pc, ep); end
        compared++; if (Pc_D !== last_pcd) begin mismatched++; $display("FAIL slow_pcd_hold[%0d.%0d] got %h exp %h", k, w, Pc_D, last_pcd); end
      end
      Imem_ack = 1'b1;
      #1;
      compared++; if (Fetch_busy !== 1'b0) begin mismatched++; $display("FAIL slow_busy_ack[%0d] got %b exp 0", k, Fetch_busy); end
      tick();
      compared++; if (Valid_D !== 1'b1) begin mismatched++; $display("FAIL slow_valid[%0d] got %b exp 1", k, Valid_D); end
      compared++; if (InstrD !== mem(ep)) begin mismatched++; $display("FAIL slow_instr[%0d] got %h exp %h", k, InstrD, mem(ep)); end
      compared++; if (Pc_D !== ep) begin mismatched++; $display("FAIL slow_pcd[%0d] got %h exp %h", k, Pc_D, ep); end
      compared++; if (Pc !== ep + 32'd4) begin mismatched++; $display("FAIL slow_pc_step[%0d] got %h exp %h", k, Pc, ep + 32'd4); end
      last_pcd = ep;
    end
  endtask

  task automatic restart();
    reset = 1'b0; Imem_ack = 1'b0; Stall = 1'b0; Flush = 1'b0;
    npc_auto = 1'b1; rd_force = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_stall_on_ack();
    restart();
    Imem_ack = 1'b1;
    tick();
    Stall = 1'b1; rd_force = 1'b1; rd_val = 32'h2408_0001;
    #1;
    compared++; if (Pc !== 32'h0000_3004) begin mismatched++; $display("FAIL stall_pc_pre got %h exp 3004", Pc); end
    tick();
    Imem_ack = 1'b0; rd_val = 32'hDEAD_BEEF;
    for (int c = 0; c < 2; c++) begin
      #1;
      compared++; if (Imem_req !== 1'b0) begin mismatched++; $display("FAIL held_req[%0d] got %b exp 0", c, Imem_req); end
      compared++; if (Fetch_busy !== 1'b0) begin mismatched++; $display("FAIL held_busy[%0d] got %b exp 0", c, Fetch_busy); end
      compared++; if (InstrD !== mem(32'h0000_3000)) begin mismatched++; $display("FAIL held_instr[%0d] got %h exp %h", c, InstrD, mem(32'h0000_3000)); end
      compared++; if (Pc_D !== 32'h0000_3000) begin mismatched++; $display("FAIL held_pcd[%0d] got %h exp 3000", c, Pc_D); end
      compared++; if (Valid_D !== 1'b1) begin mismatched++; $display("FAIL held_valid[%0d] got %b exp 1", c, Valid_D); end
      compared++; if (Pc !== 32'h0000_3004) begin mismatched++; $display("FAIL held_pc[%0d] got %h exp 3004", c, Pc); end
      tick();
    end
    Stall = 1'b0;
    tick();
    rd_force = 1'b0;
    compared++; if (InstrD !== 32'h2408_0001) begin mismatched++; $display("FAIL release_instr got %h exp 24080001", InstrD); end
    compared++; if (Pc_D !== 32'h0000_3004) begin mismatched++; $display("FAIL release_pcd got %h exp 3004", Pc_D); end
    compared++; if (Valid_D !== 1'b1) begin mismatched++; $display("FAIL release_valid got %b exp 1", Valid_D); end
    compared++; if (Pc !== 32'h0000_3008) begin mismatched++; $display("FAIL release_pc got %h exp 3008", Pc); end
    compared++; if (Imem_req !== 1'b1) begin mismatched++; $display("FAIL release_req got %b exp 1", Imem_req); end
  endtask

  // Pc = 3008, IF/ID holds 3004
  task automatic test_flush();
    Imem_ack = 1'b1; Flush = 1'b1; npc_auto = 1'b0; npc_val = 32'h0000_3100;
    tick();
    Flush = 1'b0; npc_auto = 1'b1;
    compared++; if (Valid_D !== 1'b0) begin mismatched++; $display("FAIL flush_valid got %b exp 0", Valid_D); end
    compared++; if (InstrD !== 32'h0) begin mismatched++; $display("FAIL flush_instr got %h exp 0", InstrD); end
    compared++; if (Pc_D !== 32'h0000_3004) begin mismatched++; $display("FAIL flush_pcd got %h exp 3004", Pc_D); end
    compared++; if (Pc !== 32'h0000_3100) begin mismatched++; $display("FAIL flush_pc got %h exp 3100", Pc); end
    tick();
    compared++; if (Pc_D !== 32'h0000_3100) begin mismatched++; $display("FAIL redirect_pcd got %h exp 3100", Pc_D); end
    compared++; if (InstrD !== mem(32'h0000_3100)) begin mismatched++; $display("FAIL redirect_instr got %h exp %h", InstrD, mem(32'h0000_3100)); end
    compared++; if (Valid_D !== 1'b1) begin mismatched++; $display("FAIL redirect_valid got %b exp 1", Valid_D); end
    // flush together with stall and no ack: IF/ID clears, Pc holds
    Flush = 1'b1; Stall = 1'b1; Imem_ack = 1'b0;
    tick();
    Flush = 1'b0; Stall = 1'b0;
    compared++; if (Valid_D !== 1'b0) begin mismatched++; $display("FAIL flush_stall_valid got %b exp 0", Valid_D); end
    compared++; if (Pc !== 32'h0000_3104) begin mismatched++; $display("FAIL flush_stall_pc got %h exp 3104", Pc); end
    compared++; if (Imem_req !== 1'b1) begin mismatched++; $display("FAIL flush_stall_req got %b exp 1", Imem_req); end
    // misaligned next PC is loaded unchanged
    Imem_ack = 1'b1; npc_auto = 1'b0; npc_val = 32'h0000_3102;
    tick();
    npc_auto = 1'b1;
    compared++; if (Pc !== 32'h0000_3102) begin mismatched++; $display("FAIL misaligned_pc got %h exp 3102", Pc); end
  endtask

  task automatic test_async_reset();
    Imem_ack = 1'b1; Stall = 1'b1;
    tick();
    compared++; if (Imem_req !== 1'b0) begin mismatched++; $display("FAIL pre_areset_held got %b exp 0", Imem_req); end
    #2;
    reset = 1'b0;
    #1;
    compared++; if (Pc !== 32'h0000_3000) begin mismatched++; $display("FAIL areset_pc got %h exp 3000", Pc); end
    compared++; if (Valid_D !== 1'b0) begin mismatched++; $display("FAIL areset_valid got %b exp 0", Valid_D); end
    compared++; if (InstrD !== 32'h0) begin mismatched++; $display("FAIL areset_instr got %h exp 0", InstrD); end
    compared++; if (Pc_D !== 32'h0) begin mismatched++; $display("FAIL areset_pcd got %h exp 0", Pc_D); end
    compared++; if (Imem_req !== 1'b1) begin mismatched++; $display("FAIL areset_req got %b exp 1", Imem_req); end
    #1;
    reset = 1'b1; Stall = 1'b0;
    tick();
    compared++; if (Pc_D !== 32'h0000_3000) begin mismatched++; $display("FAIL restart_pcd got %h exp 3000", Pc_D); end
    compared++; if (InstrD !== mem(32'h0000_3000)) begin mismatched++; $display("FAIL restart_instr got %h exp %h", InstrD, mem(32'h0000_3000)); end
    compared++; if (Valid_D !== 1'b1) begin mismatched++; $display("FAIL restart_valid got %b exp 1", Valid_D); end
    compared++; if (Pc !== 32'h0000_3004) begin mismatched++; $display("FAIL restart_pc got %h exp 3004", Pc); end
  endtask

  initial begin
    compared = 0; mismatched = 0;
    reset = 1'b0; Stall = 1'b0; Flush = 1'b0; Imem_ack = 1'b0;
    npc_auto = 1'b1; npc_val = 32'h0; rd_force = 1'b0; rd_val = 32'h0;
    test_reset();
    test_slow_mem();
    test_stall_on_ack();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
